dcache_sa: RTL and testbench

DCACHE_SA -- requirements
Module: dcache_sa

---
 rtl/dcache_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/dcache_sa.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_dcache_sa.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the set-associative data cache: controller states and
// address-field width helpers.
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EVICT,
    REFILL,
    RESPOND,
    FLUSH_SCAN,
    FLUSH_WB
  } state_t;

  // Width of an index field selecting one of n items; 0 when n <= 1.
  function automatic int unsigned field_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  // Physical vector width for a field that may be zero-width.
  function automatic int unsigned nz(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves just past the winner when advance is high.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] request,
  output logic [N-1:0] grant,
  input  logic         advance
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gsel;
  logic          found;
  int unsigned   k;

  always_comb begin
    grant = '0;
    gsel  = '0;
    found = 1'b0;
    k     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!found && request[k]) begin
        grant[k] = 1'b1;
        gsel     = PW'(k);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (gsel == PW'(N - 1)) ? '0 : gsel + 1'b1;
    end
  end

endmodule

// File: rtl/dcache_sa.sv
// Write-back, write-allocate set-associative data cache shared by several
// byte-wide load/store ports, with block-wide memory refill/write-back and flush.
module dcache_sa
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned NUM_CONSUMERS = 4,
  parameter int unsigned NUM_SETS      = 4,
  parameter int unsigned NUM_WAYS      = 2,
  parameter int unsigned BLOCK_BYTES   = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] read_address,
  output logic [NUM_CONSUMERS-1:0]           read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] read_data,
  input  logic [NUM_CONSUMERS-1:0]           write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] write_data,
  output logic [NUM_CONSUMERS-1:0]           write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [BLOCK_BYTES*8-1:0]           mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [BLOCK_BYTES*8-1:0]           mem_write_data,
  input  logic                               mem_write_ready,
  input  logic                               flush_valid,
  output logic                               flush_ready
);

  localparam int unsigned OFF_W   = field_bits(BLOCK_BYTES);
  localparam int unsigned IDX_W   = field_bits(NUM_SETS);
  localparam int unsigned TAG_W   = ADDR_BITS - IDX_W - OFF_W;
  localparam int unsigned OFF_WS  = nz(OFF_W);
  localparam int unsigned IDX_WS  = nz(IDX_W);
  localparam int unsigned WAY_WS  = nz(field_bits(NUM_WAYS));
  localparam int unsigned CONS_WS = nz(field_bits(NUM_CONSUMERS));
  localparam int unsigned LINE_W  = BLOCK_BYTES * 8;

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_BITS-1:0] a);
    return TAG_W'(a >> (IDX_W + OFF_W));
  endfunction

  function automatic logic [IDX_WS-1:0] idx_of(input logic [ADDR_BITS-1:0] a);
    return (IDX_W == 0) ? '0 : IDX_WS'(a >> OFF_W);
  endfunction

  function automatic logic [OFF_WS-1:0] off_of(input logic [ADDR_BITS-1:0] a);
    return (OFF_W == 0) ? '0 : OFF_WS'(a);
  endfunction

  function automatic logic [ADDR_BITS-1:0] make_addr(input logic [TAG_W-1:0] t,
                                                     input logic [IDX_WS-1:0] s);
    return (ADDR_BITS'(t) << (IDX_W + OFF_W)) | (ADDR_BITS'(s) << OFF_W);
  endfunction

  // Touched way becomes MRU; once every way is MRU the others are cleared.
  function automatic logic [NUM_WAYS-1:0] mru_touch(input logic [NUM_WAYS-1:0] m,
                                                    input logic [WAY_WS-1:0] w);
    logic [NUM_WAYS-1:0] n;
    n    = m;
    n[w] = 1'b1;
    if (&n) begin
      n    = '0;
      n[w] = 1'b1;
    end
    return n;
  endfunction

  state_t                state;
  logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]   dirty_q [NUM_SETS];
  logic [NUM_WAYS-1:0]   mru_q   [NUM_SETS];
  logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0]     data_q  [NUM_SETS][NUM_WAYS];

  logic [CONS_WS-1:0]    cur_cons;
  logic                  cur_write;
  logic [ADDR_BITS-1:0]  cur_addr;
  logic [DATA_BITS-1:0]  cur_wdata;
  logic [IDX_WS-1:0]     cur_set;
  logic [WAY_WS-1:0]     cur_way;
  logic [IDX_WS-1:0]     scan_set;
  logic [WAY_WS-1:0]     scan_way;
  logic                  scan_last;

  logic [NUM_CONSUMERS-1:0] blocked;
  logic                     flush_blocked;
  logic [NUM_CONSUMERS-1:0] arb_req;
  logic [NUM_CONSUMERS-1:0] arb_grant;
  logic                     arb_advance;
  logic                     take_flush;

  logic [CONS_WS-1:0]    gidx;
  logic                  g_write;
  logic [ADDR_BITS-1:0]  g_addr;
  logic [DATA_BITS-1:0]  g_wdata;
  logic [IDX_WS-1:0]     g_set;
  logic [TAG_W-1:0]      g_tag;
  logic [OFF_WS-1:0]     g_off;
  logic                  hit;
  logic [WAY_WS-1:0]     hit_way;
  logic                  vic_found;
  logic [WAY_WS-1:0]     victim;
  logic [LINE_W-1:0]     refill_line;

  assign take_flush  = flush_valid && !flush_blocked;
  assign arb_req     = (read_valid | write_valid) & ~blocked;
  assign arb_advance = (state == IDLE) && !take_flush;
  assign scan_last   = (scan_set == IDX_WS'(NUM_SETS - 1)) && (scan_way == WAY_WS'(NUM_WAYS - 1));

  rr_arbiter #(.N(NUM_CONSUMERS)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .request (arb_req),
    .grant   (arb_grant),
    .advance (arb_advance)
  );

  always_comb begin
    gidx = '0;
    for (int unsigned c = 0; c < NUM_CONSUMERS; c++) begin
      if (arb_grant[c]) gidx = CONS_WS'(c);
    end
    g_write = write_valid[gidx] && !read_valid[gidx];
    g_addr  = g_write ? write_address[gidx*ADDR_BITS +: ADDR_BITS]
                      : read_address[gidx*ADDR_BITS +: ADDR_BITS];
    g_wdata = write_data[gidx*DATA_BITS +: DATA_BITS];
    g_set   = idx_of(g_addr);
    g_tag   = tag_of(g_addr);
    g_off   = off_of(g_addr);

    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!hit && valid_q[g_set][w] && tag_q[g_set][w] == g_tag) begin
        hit     = 1'b1;
        hit_way = WAY_WS'(w);
      end
    end

    vic_found = 1'b0;
    victim    = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!vic_found && !valid_q[g_set][w]) begin
        vic_found = 1'b1;
        victim    = WAY_WS'(w);
      end
    end
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!vic_found && !mru_q[g_set][w]) begin
        vic_found = 1'b1;
        victim    = WAY_WS'(w);
      end
    end

    refill_line = mem_read_data;
    if (cur_write) refill_line[off_of(cur_addr)*8 +: 8] = 8'(cur_wdata);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      read_ready        <= '0;
      write_ready       <= '0;
      read_data         <= '0;
      mem_read_valid    <= 1'b0;
      mem_read_address  <= '0;
      mem_write_valid   <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      flush_ready       <= 1'b0;
      blocked           <= '0;
      flush_blocked     <= 1'b0;
      cur_cons          <= '0;
      cur_write         <= 1'b0;
      cur_addr          <= '0;
      cur_wdata         <= '0;
      cur_set           <= '0;
      cur_way           <= '0;
      scan_set          <= '0;
      scan_way          <= '0;
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        mru_q[s]   <= '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) tag_q[s][w] <= '0;
      end
    end else begin
      read_ready  <= '0;
      write_ready <= '0;
      flush_ready <= 1'b0;
      // A served port is re-armed only after its valid is seen low once.
      for (int unsigned c = 0; c < NUM_CONSUMERS; c++) begin
        if (!(read_valid[c] || write_valid[c])) blocked[c] <= 1'b0;
      end
      if (!flush_valid) flush_blocked <= 1'b0;

      case (state)
        IDLE: begin
          if (take_flush) begin
            scan_set <= '0;
            scan_way <= '0;
            state    <= FLUSH_SCAN;
          end else if (|arb_grant) begin
            cur_cons  <= gidx;
            cur_write <= g_write;
            cur_addr  <= g_addr;
            cur_wdata <= g_wdata;
            cur_set   <= g_set;
            if (hit) begin
              mru_q[g_set] <= mru_touch(mru_q[g_set], hit_way);
              blocked[gidx] <= 1'b1;
              if (g_write) begin
                data_q[g_set][hit_way][g_off*8 +: 8] <= 8'(g_wdata);
                dirty_q[g_set][hit_way] <= 1'b1;
                write_ready[gidx] <= 1'b1;
              end else begin
                read_data[gidx*DATA_BITS +: DATA_BITS] <=
                  DATA_BITS'(data_q[g_set][hit_way][g_off*8 +: 8]);
                read_ready[gidx] <= 1'b1;
              end
            end else begin
              cur_way <= victim;
              if (valid_q[g_set][victim] && dirty_q[g_set][victim]) begin
                mem_write_valid   <= 1'b1;
                mem_write_address <= make_addr(tag_q[g_set][victim], g_set);
                mem_write_data    <= data_q[g_set][victim];
                state             <= EVICT;
              end else begin
                mem_read_valid   <= 1'b1;
                mem_read_address <= make_addr(g_tag, g_set);
                state            <= REFILL;
              end
            end
          end
        end

        EVICT: begin
          if (mem_write_valid && mem_write_ready) begin
            mem_write_valid  <= 1'b0;
            mem_read_valid   <= 1'b1;
            mem_read_address <= make_addr(tag_of(cur_addr), cur_set);
            state            <= REFILL;
          end
        end

        REFILL: begin
          if (mem_read_valid && mem_read_ready) begin
            mem_read_valid             <= 1'b0;
            valid_q[cur_set][cur_way]  <= 1'b1;
            dirty_q[cur_set][cur_way]  <= cur_write;
            mru_q[cur_set]             <= mru_touch(mru_q[cur_set], cur_way);
            tag_q[cur_set][cur_way]    <= tag_of(cur_addr);
            data_q[cur_set][cur_way]   <= refill_line;
            state                      <= RESPOND;
          end
        end

        RESPOND: begin
          blocked[cur_cons] <= 1'b1;
          if (cur_write) begin
            write_ready[cur_cons] <= 1'b1;
          end else begin
            read_ready[cur_cons] <= 1'b1;
            read_data[cur_cons*DATA_BITS +: DATA_BITS] <=
              DATA_BITS'(data_q[cur_set][cur_way][off_of(cur_addr)*8 +: 8]);
          end
          state <= IDLE;
        end

        FLUSH_SCAN, FLUSH_WB: begin
          // Clean lines retire in one scan cycle; dirty ones detour through FLUSH_WB.
          if (state == FLUSH_SCAN && valid_q[scan_set][scan_way] && dirty_q[scan_set][scan_way]) begin
            mem_write_valid   <= 1'b1;
            mem_write_address <= make_addr(tag_q[scan_set][scan_way], scan_set);
            mem_write_data    <= data_q[scan_set][scan_way];
            state             <= FLUSH_WB;
          end else if (state == FLUSH_SCAN || (mem_write_valid && mem_write_ready)) begin
            mem_write_valid             <= 1'b0;
            valid_q[scan_set][scan_way] <= 1'b0;
            dirty_q[scan_set][scan_way] <= 1'b0;
            mru_q[scan_set][scan_way]   <= 1'b0;
            if (scan_last) begin
              flush_ready   <= 1'b1;
              flush_blocked <= 1'b1;
              state         <= IDLE;
            end else begin
              state <= FLUSH_SCAN;
              if (scan_way == WAY_WS'(NUM_WAYS - 1)) begin
                scan_way <= '0;
                scan_set <= scan_set + 1'b1;
              end else begin
                scan_way <= scan_way + 1'b1;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_sa.sv
// Scoreboard bench for dcache_sa: a byte-accurate memory model answers the
// cache, and every consumer response is checked against a golden byte image.
module tb_dcache_sa;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  read_valid = '0, write_valid = '0;
  logic [31:0] read_address = '0, write_address = '0, write_data = '0;
  logic [3:0]  read_ready, write_ready;
  logic [31:0] read_data;
  logic        mem_read_valid, mem_write_valid;
  logic [7:0]  mem_read_address, mem_write_address;
  logic        mem_read_ready = 1'b0, mem_write_ready = 1'b0;
  logic [31:0] mem_read_data = '0, mem_write_data;
  logic        flush_valid = 1'b0, flush_ready;

  typedef struct { int cons; bit wr; logic [7:0] data; } exp_t;
  typedef struct { bit wr; logic [7:0] addr; logic [31:0] data; } mem_ev_t;

  exp_t       sb[$];
  mem_ev_t    log_q[$];
  logic [7:0] mem  [256];
  logic [7:0] gold [256];
  int         vectors = 0, miscompares = 0;
  bit         mem_hold = 1'b0;
  bit         both_seen = 1'b0;
  int         rd_wait = 0;

  dcache_sa #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4),
              .NUM_SETS(4), .NUM_WAYS(2), .BLOCK_BYTES(4)) dut (
    .clk(clk), .reset(reset),
    .read_valid(read_valid), .read_address(read_address),
    .read_ready(read_ready), .read_data(read_data),
    .write_valid(write_valid), .write_address(write_address),
    .write_data(write_data), .write_ready(write_ready),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .flush_valid(flush_valid), .flush_ready(flush_ready)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Memory model: reads answer after two sampled cycles, writes after one;
  // ready wiggles randomly while the matching valid is low.
  initial forever begin
    @(negedge clk);
    if (mem_read_valid && mem_write_valid) both_seen = 1'b1;
    mem_read_ready  = !mem_read_valid  && ($urandom_range(0, 1) == 1);
    mem_write_ready = !mem_write_valid && ($urandom_range(0, 1) == 1);
    if (reset || mem_hold) begin
      rd_wait         = 0;
      mem_read_ready  = 1'b0;
      mem_write_ready = 1'b0;
      continue;
    end
    if (mem_read_valid) begin
      rd_wait++;
      if (rd_wait >= 2) begin
        for (int b = 0; b < 4; b++) mem_read_data[b*8 +: 8] = mem[(int'(mem_read_address) + b) & 255];
        mem_read_ready = 1'b1;
        log_q.push_back('{1'b0, mem_read_address, mem_read_data});
        rd_wait = 0;
      end
    end else begin
      rd_wait = 0;
    end
    if (mem_write_valid) begin
      for (int b = 0; b < 4; b++) mem[(int'(mem_write_address) + b) & 255] = mem_write_data[b*8 +: 8];
      mem_write_ready = 1'b1;
      log_q.push_back('{1'b1, mem_write_address, mem_write_data});
    end
  end

  // Response monitor: every ready pulse pops one expectation.
  initial forever begin
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      if (read_ready[c] === 1'b1 || write_ready[c] === 1'b1) begin
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL resp_unexpected port %0d got rd=%b wr=%b want no response", c, read_ready[c], write_ready[c]);
        end else begin
          e = sb.pop_front();
          if (e.cons != c || e.wr != write_ready[c] || (!e.wr && read_data[c*8 +: 8] !== e.data)) begin
            miscompares++;
            $display("FAIL resp port %0d got wr=%b data=%h want port %0d wr=%b data=%h",
                     c, write_ready[c], read_data[c*8 +: 8], e.cons, e.wr, e.data);
          end
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    read_valid = '0; write_valid = '0; flush_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    log_q.delete();
    gold = mem;
    @(negedge clk);
  endtask

  task automatic access(input int c, input bit wr, input logic [7:0] addr,
                        input logic [7:0] wd, output int waited);
    sb.push_back('{c, wr, wr ? 8'h00 : gold[addr]});
    if (wr) begin
      gold[addr] = wd;
      write_address[c*8 +: 8] = addr;
      write_data[c*8 +: 8]    = wd;
      write_valid[c]          = 1'b1;
    end else begin
      read_address[c*8 +: 8] = addr;
      read_valid[c]          = 1'b1;
    end
    waited = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (read_ready[c] === 1'b1 || write_ready[c] === 1'b1) begin
        waited = i;
        break;
      end
    end
    read_valid[c] = 1'b0;
    write_valid[c] = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_flush(output int pulses);
    pulses = 0;
    flush_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (flush_ready === 1'b1) begin
        pulses++;
        break;
      end
    end
    flush_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (flush_ready === 1'b1) pulses++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (read_ready !== 4'h0 || write_ready !== 4'h0 || flush_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready got rd=%h wr=%h fl=%b want 0", read_ready, write_ready, flush_ready);
    end
    vectors++;
    if (mem_read_valid !== 1'b0 || mem_write_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mem_valid got r=%b w=%b want 0", mem_read_valid, mem_write_valid);
    end
    vectors++;
    if (read_data !== 32'h0 || mem_read_address !== 8'h0 || mem_write_address !== 8'h0 || mem_write_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data got rd=%h ra=%h wa=%h wd=%h want 0", read_data, mem_read_address, mem_write_address, mem_write_data);
    end
    do_reset();
  endtask

  task automatic test_read_miss_hit();
    int lat;
    do_reset();
    access(0, 1'b0, 8'h10, 8'h00, lat);
    vectors++;
    if (lat !== 4) begin miscompares++; $display("FAIL miss_latency got %0d want 4", lat); end
    vectors++;
    if (log_q.size() !== 1 || log_q[0].wr !== 1'b0 || log_q[0].addr !== 8'h10) begin
      miscompares++;
      $display("FAIL miss_refill_addr got n=%0d addr=%h want 1 read at 10", log_q.size(), log_q.size() > 0 ? log_q[0].addr : 8'hxx);
    end
    access(0, 1'b0, 8'h12, 8'h00, lat);
    vectors++;
    if (lat !== 1) begin miscompares++; $display("FAIL hit_latency got %0d want 1", lat); end
    vectors++;
    if (log_q.size() !== 1) begin miscompares++; $display("FAIL hit_no_traffic got %0d events want 1", log_q.size()); end
  endtask

  task automatic test_write_allocate();
    int lat, pulses;
    logic [31:0] want;
    do_reset();
    access(1, 1'b1, 8'h21, 8'hAA, lat);
    vectors++;
    if (lat !== 4) begin miscompares++; $display("FAIL wmiss_latency got %0d want 4", lat); end
    access(1, 1'b0, 8'h21, 8'h00, lat);
    vectors++;
    if (lat !== 1) begin miscompares++; $display("FAIL wa_read_hit got latency %0d want 1", lat); end
    vectors++;
    if (log_q.size() !== 1 || log_q[0].addr !== 8'h20) begin
      miscompares++;
      $display("FAIL wa_single_refill got %0d events want 1 read at 20", log_q.size());
    end
    log_q.delete();
    do_flush(pulses);
    want = {gold[8'h23], gold[8'h22], gold[8'h21], gold[8'h20]};
    vectors++;
    if (log_q.size() !== 1 || !log_q[0].wr || log_q[0].addr !== 8'h20 || log_q[0].data !== want) begin
      miscompares++;
      $display("FAIL wa_dirty_writeback got n=%0d data=%h want 1 write at 20 data=%h",
               log_q.size(), log_q.size() > 0 ? log_q[0].data : 32'hx, want);
    end
  endtask

  task automatic test_evict();
    int lat;
    logic [31:0] want;
    do_reset();
    access(0, 1'b1, 8'h00, 8'h5C, lat);
    access(0, 1'b0, 8'h40, 8'h00, lat);
    log_q.delete();
    want = {gold[8'h03], gold[8'h02], gold[8'h01], gold[8'h00]};
    access(2, 1'b0, 8'h80, 8'h00, lat);
    vectors++;
    if (lat !== 5) begin miscompares++; $display("FAIL evict_latency got %0d want 5", lat); end
    vectors++;
    if (log_q.size() !== 2) begin
      miscompares++;
      $display("FAIL evict_events got %0d want 2", log_q.size());
    end else begin
      vectors++;
      if (!log_q[0].wr || log_q[0].addr !== 8'h00 || log_q[0].data !== want || log_q[1].wr || log_q[1].addr !== 8'h80) begin
        miscompares++;
        $display("FAIL evict_order got %b@%h(%h) %b@%h want 1@00(%h) 0@80",
                 log_q[0].wr, log_q[0].addr, log_q[0].data, log_q[1].wr, log_q[1].addr, want);
      end
    end
    access(2, 1'b0, 8'h41, 8'h00, lat);
    vectors++;
    if (lat !== 1 || log_q.size() !== 2) begin
      miscompares++;
      $display("FAIL evict_keep_40 got latency %0d events %0d want 1 and 2", lat, log_q.size());
    end
  endtask

  task automatic test_round_robin();
    int lat;
    int seen[4];
    do_reset();
    access(3, 1'b0, 8'h10, 8'h00, lat);
    for (int c = 0; c < 4; c++) begin
      seen[c] = 0;
      sb.push_back('{c, 1'b0, gold[8'h10 + c]});
      read_address[c*8 +: 8] = 8'(8'h10 + c);
    end
    read_valid = 4'hF;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        if (read_ready[c] === 1'b1 && seen[c] == 0) begin
          seen[c] = i;
          read_valid[c] = 1'b0;
        end
      end
      if (read_valid == 4'h0) break;
    end
    read_valid = 4'h0;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (seen[c] !== c + 1) begin
        miscompares++;
        $display("FAIL rr_order port %0d got cycle %0d want %0d", c, seen[c], c + 1);
      end
    end
  endtask

  task automatic test_flush();
    int lat, pulses;
    do_reset();
    access(0, 1'b1, 8'h21, 8'hAA, lat);
    access(1, 1'b1, 8'h35, 8'hBB, lat);
    access(2, 1'b0, 8'h48, 8'h00, lat);
    log_q.delete();
    do_flush(pulses);
    vectors++;
    if (pulses !== 1) begin miscompares++; $display("FAIL flush_ready_pulses got %0d want 1", pulses); end
    vectors++;
    if (log_q.size() !== 2) begin
      miscompares++;
      $display("FAIL flush_writebacks got %0d want 2", log_q.size());
    end else begin
      vectors++;
      if (!log_q[0].wr || log_q[0].addr !== 8'h20 || !log_q[1].wr || log_q[1].addr !== 8'h34 || log_q[1].data[15:8] !== 8'hBB) begin
        miscompares++;
        $display("FAIL flush_wb_addr got %h,%h byte=%h want 20,34 byte=bb", log_q[0].addr, log_q[1].addr, log_q[1].data[15:8]);
      end
    end
    access(3, 1'b0, 8'h21, 8'h00, lat);
    vectors++;
    if (lat !== 4) begin miscompares++; $display("FAIL flush_miss_dirty got latency %0d want 4", lat); end
    access(3, 1'b0, 8'h48, 8'h00, lat);
    vectors++;
    if (lat !== 4) begin miscompares++; $display("FAIL flush_miss_clean got latency %0d want 4", lat); end
  endtask

  task automatic test_reset_mid_refill();
    int lat;
    do_reset();
    mem_hold = 1'b1;
    read_address[7:0] = 8'h10;
    read_valid[0] = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (mem_read_valid !== 1'b1) begin miscompares++; $display("FAIL refill_pending got %b want 1", mem_read_valid); end
    reset = 1'b1;
    read_valid[0] = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_read_valid !== 1'b0 || mem_read_address !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_abandon got valid=%b addr=%h want 0 00", mem_read_valid, mem_read_address);
    end
    mem_hold = 1'b0;
    do_reset();
    access(0, 1'b0, 8'h10, 8'h00, lat);
    vectors++;
    if (lat !== 4 || log_q.size() !== 1 || log_q[0].addr !== 8'h10) begin
      miscompares++;
      $display("FAIL rerefill got latency %0d events %0d want 4 and 1 read at 10", lat, log_q.size());
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'h5A;
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    gold = mem;
    test_reset();
    test_read_miss_hit();
    test_write_allocate();
    test_evict();
    test_round_robin();
    test_flush();
    test_reset_mid_refill();
    repeat (4) @(negedge clk);
    vectors++;
    if (both_seen !== 1'b0) begin miscompares++; $display("FAIL mem_valid_exclusive got both high want never"); end
    vectors++;
    if (sb.size() !== 0) begin miscompares++; $display("FAIL sb_drain got %0d pending want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
